// File: rtl/spi_kbd_fifo.sv
// spi_kbd_fifo: SPI-slave (mode 0) keyboard receiver with a DEPTH-entry FIFO.
// SCK/MOSI/CS_N are oversampled in the clk domain and assembled into MSB-first
// DATA_W-bit words, which are queued for the CPU. It has a pop strobe and
// sticky overflow/frame error flags.
// Optional feature: define SPI_KBD_OVERWRITE_EN so that a push into a full
// FIFO discards the oldest entry. When the macro is undefined, the new word
// is dropped instead.
module spi_kbd_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sck,
  input  logic                       mosi,
  input  logic                       cs_n,
  input  logic                       rd,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          key,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       frame_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int BIT_W = $clog2(DATA_W+1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sckSync_q, mosiSync_q, csSync_q;
  logic                   sckDly_q, csDly_q;
  logic                   sckS, mosiS, csS, sckRise, csFall, csRise;

  state_t                 state_q, state_d;
  logic [BIT_W-1:0]       bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d, pushWord;
  logic                   push, frameEvt;

  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]       rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d, frameErr_q, frameErr_d;
  logic                   full, doPop, wrEn, ovfEvt;

  // Synchronise the SPI pins and keep one delay flop for edge detection. The
  // cs_n chain resets to 0, so a frame already in progress at reset produces
  // no falling edge and is ignored until cs_n cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sckSync_q  <= '0;
      mosiSync_q <= '0;
      csSync_q   <= '0;
      sckDly_q   <= 1'b0;
      csDly_q    <= 1'b0;
    end else begin
      sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], sck};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_n};
      sckDly_q   <= sckSync_q[SYNC_STAGES-1];
      csDly_q    <= csSync_q[SYNC_STAGES-1];
    end
  end

  assign sckS    = sckSync_q[SYNC_STAGES-1];
  assign mosiS   = mosiSync_q[SYNC_STAGES-1];
  assign csS     = csSync_q[SYNC_STAGES-1];
  assign sckRise = sckS & ~sckDly_q;
  assign csFall  = ~csS & csDly_q;
  assign csRise  = csS & ~csDly_q;

  assign pushWord = {shift_q[DATA_W-2:0], mosiS};

  // Receive FSM: shift one bit per synced sck rise and push each complete word.
  // A frame that ends with a partial word raises a frame error.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    push     = 1'b0;
    frameEvt = 1'b0;
    case (state_q)
      IDLE: begin
        bitCnt_d = '0;
        if (csFall) state_d = SHIFT;
      end
      SHIFT: begin
        if (csRise) begin
          state_d  = IDLE;
          bitCnt_d = '0;
          frameEvt = (bitCnt_q != '0);
        end else if (sckRise) begin
          shift_d = pushWord;
          if (bitCnt_q == BIT_W'(DATA_W-1)) begin
            push     = 1'b1;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign doPop = rd & valid;

  // FIFO bookkeeping: pointers, occupancy and the sticky flags. A pop makes
  // room for a simultaneous push even when the FIFO is full.
  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    wrEn       = 1'b0;
    ovfEvt     = 1'b0;
    if (doPop) rdPtr_d = rdPtr_q + PTR_W'(1);
    if (push) begin
      if (!full || doPop) begin
        wrEn = 1'b1;
      end else begin
        ovfEvt = 1'b1;
`ifdef SPI_KBD_OVERWRITE_EN
        wrEn    = 1'b1;
        rdPtr_d = rdPtr_q + PTR_W'(1);
`endif
      end
    end
    if (wrEn) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (push && (!full || doPop) && !doPop) count_d = count_q + CNT_W'(1);
    else if (doPop && !push)                count_d = count_q - CNT_W'(1);
    overflow_d = clr_err ? 1'b0 : overflow_q;
    if (ovfEvt) overflow_d = 1'b1;
    frameErr_d = clr_err ? 1'b0 : frameErr_q;
    if (frameEvt) frameErr_d = 1'b1;
  end

  // State registers for the receiver and the FIFO control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      frameErr_q <= frameErr_d;
    end
  end

  // FIFO storage; contents need no reset because reads are gated by valid.
  always_ff @(posedge clk) begin
    if (wrEn) mem_q[wrPtr_q] <= pushWord;
  end

  assign valid     = (count_q != '0);
  assign key       = valid ? mem_q[rdPtr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign frame_err = frameErr_q;

endmodule
